fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID register. It owns the fetch PC, issues requests to instruction memory over a req/ack handshake, and presents `inst_o`/`pc_o` to IF/ID. It inserts NOP bubbles (`32'b0`) when memory is slow, buffers one returned instruction while the pipeline is stalled, and redirects on branch/jump.

---
 rtl/fetch_stage.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. It owns the fetch PC, runs a req/ack
// handshake to instruction memory, inserts NOP bubbles (32'b0) while memory is
// slow, parks one returned instruction during a pipeline stall and handles
// branch/jump redirects, including dropping a stale in-flight response.
// Optional build macro: FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pcEnable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  // Low address bits are forced to zero so fetches are always word aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_r, state_s;
  logic [31:0] fpc_r, fpc_s;
  logic [31:0] buf_inst_r, buf_inst_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] pc_r, pc_s;
  logic        fetch_s;
  logic        bubble_s;
  logic [31:0] target_s;
  logic [31:0] fpc_inc_s;

  assign target_s    = branch_target_i & 32'hFFFF_FFFC;
  assign fpc_inc_s   = fpc_r + 32'd4;   // wraps modulo 2^32
  assign imem_addr_o = fpc_r;
  assign imem_req_o  = (state_r == REQ) || (state_r == DROP);
  assign inst_o      = inst_r;
  assign pc_o        = pc_r;

  // State register; reset returns to IDLE immediately, dropping any transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath decode; a redirect always wins over a stall.
  always_comb begin
    state_s    = state_r;
    fpc_s      = fpc_r;
    buf_inst_s = buf_inst_r;
    buf_pc_s   = buf_pc_r;
    inst_s     = inst_r;
    pc_s       = pc_r;
    fetch_s    = 1'b0;
    bubble_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Any ack seen here is ignored: no request has been issued yet.
        state_s = REQ;
        if (pcEnable_i) begin
          inst_s   = 32'd0;
          bubble_s = 1'b1;
        end else begin
          inst_s = inst_r;
        end
      end
      REQ: begin
        if (branch_i) begin
          fpc_s    = target_s;
          inst_s   = 32'd0;
          bubble_s = pcEnable_i;
          if (imem_ack_i) begin
            state_s = REQ;
          end else begin
            state_s = DROP;   // the in-flight response must be discarded
          end
        end else if (imem_ack_i && pcEnable_i) begin
          inst_s  = imem_rdata_i;
          pc_s    = fpc_inc_s;
          fpc_s   = fpc_inc_s;
          fetch_s = 1'b1;
        end else if (imem_ack_i) begin
          buf_inst_s = imem_rdata_i;
          buf_pc_s   = fpc_inc_s;
          fpc_s      = fpc_inc_s;
          state_s    = HOLD;
        end else if (pcEnable_i) begin
          inst_s   = 32'd0;
          bubble_s = 1'b1;
        end else begin
          inst_s = inst_r;
        end
      end
      HOLD: begin
        if (branch_i) begin
          buf_inst_s = 32'd0;
          buf_pc_s   = 32'd0;
          fpc_s      = target_s;
          inst_s     = 32'd0;
          bubble_s   = pcEnable_i;
          state_s    = REQ;
        end else if (pcEnable_i) begin
          inst_s  = buf_inst_r;
          pc_s    = buf_pc_r;
          fetch_s = 1'b1;
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        if (branch_i) begin
          fpc_s   = target_s;
          state_s = DROP;
        end else if (imem_ack_i) begin
          state_s = REQ;      // stale data discarded
        end else begin
          state_s = DROP;
        end
        if (pcEnable_i) begin
          inst_s   = 32'd0;
          bubble_s = 1'b1;
        end else begin
          inst_s = inst_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Fetch PC, stall buffer and registered IF/ID outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fpc_r      <= RESET_PC_ALIGNED;
      buf_inst_r <= 32'd0;
      buf_pc_r   <= 32'd0;
      inst_r     <= 32'd0;
      pc_r       <= 32'd0;
    end else begin
      fpc_r      <= fpc_s;
      buf_inst_r <= buf_inst_s;
      buf_pc_r   <= buf_pc_s;
      inst_r     <= inst_s;
      pc_r       <= pc_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] bubble_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

  assign fetch_cnt_o  = fetch_cnt_r;
  assign bubble_cnt_o = bubble_cnt_r;

  // Saturating counters of delivered instructions and inserted bubbles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      if (fetch_s) begin
        fetch_cnt_r <= sat_inc(fetch_cnt_r);
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (bubble_s) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end
`else
  logic unused_perf_s;
  assign unused_perf_s = fetch_s ^ bubble_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized stimulus for fetch_stage, checked
// against a transaction-level reference model held in the bench.
module tb_fetch_stage;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pcEnable_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  // Second instance: RESET_PC at the top of memory, zero-wait memory returning the address.
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] inst2;
  logic [31:0] pc2;
  logic        ack2;
  logic [31:0] rdata2;
  assign ack2   = req2;
  assign rdata2 = addr2;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
  logic [31:0] fetch_cnt2;
  logic [31:0] bubble_cnt2;
`endif

  fetch_stage u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .pcEnable_i(pcEnable_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .inst_o(inst_o), .pc_o(pc_o)
`ifdef FETCH_PERF_EN
    , .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .pcEnable_i(1'b1), .branch_i(1'b0),
    .branch_target_i(32'd0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2), .inst_o(inst2), .pc_o(pc2)
`ifdef FETCH_PERF_EN
    , .fetch_cnt_o(fetch_cnt2), .bubble_cnt_o(bubble_cnt2)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transaction view (started / request outstanding / stale / parked).
  logic        m_started;
  logic        m_stale;
  logic        m_held;
  logic [31:0] m_fpc;
  logic [31:0] m_buf_inst;
  logic [31:0] m_buf_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [31:0] m_fetches;
  logic [31:0] m_bubbles;

  logic        r_en;
  logic        r_br;
  logic        r_ack;
  logic [31:0] r_tgt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC000_0003;   // never zero for an aligned address
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started  = 1'b0;
    m_stale    = 1'b0;
    m_held     = 1'b0;
    m_fpc      = 32'd0;
    m_buf_inst = 32'd0;
    m_buf_pc   = 32'd0;
    m_inst     = 32'd0;
    m_pc       = 32'd0;
    m_fetches  = 32'd0;
    m_bubbles  = 32'd0;
  endtask

  task automatic bubble(input logic en);
    m_inst = 32'd0;
    if (en && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 32'd1;
  endtask

  task automatic deliver(input logic [31:0] inst, input logic [31:0] pc);
    m_inst = inst;
    m_pc   = pc;
    if (m_fetches != 32'hFFFF_FFFF) m_fetches = m_fetches + 32'd1;
  endtask

  task automatic model_step(input logic en, input logic br, input logic [31:0] tgt,
                            input logic ack, input logic [31:0] rdata);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (!m_started) begin
      m_started = 1'b1;
      if (en) bubble(1'b1);
    end else if (m_held) begin
      if (br) begin
        m_held = 1'b0;
        m_fpc  = t;
        bubble(en);
      end else if (en) begin
        m_held = 1'b0;
        deliver(m_buf_inst, m_buf_pc);
      end
    end else if (m_stale) begin
      if (br) m_fpc = t;
      else if (ack) m_stale = 1'b0;
      if (en) bubble(1'b1);
    end else begin
      if (br) begin
        m_fpc = t;
        if (!ack) m_stale = 1'b1;
        bubble(en);
      end else if (ack && en) begin
        deliver(rdata, m_fpc + 32'd4);
        m_fpc = m_fpc + 32'd4;
      end else if (ack) begin
        m_buf_inst = rdata;
        m_buf_pc   = m_fpc + 32'd4;
        m_fpc      = m_fpc + 32'd4;
        m_held     = 1'b1;
      end else if (en) begin
        bubble(1'b1);
      end
    end
  endtask

  task automatic check_all();
    check("req",  {31'd0, imem_req_o}, {31'd0, m_started && !m_held});
    check("addr", imem_addr_o, m_fpc);
    check("inst", inst_o, m_inst);
    check("pc",   pc_o, m_pc);
`ifdef FETCH_PERF_EN
    check("fetch_cnt",  fetch_cnt_o, m_fetches);
    check("bubble_cnt", bubble_cnt_o, m_bubbles);
`endif
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic en, input logic br, input logic [31:0] tgt, input logic ack_in);
    logic        ack_d;
    logic [31:0] rd;
    ack_d           = ack_in && !m_held;   // memory only answers a live request
    rd              = mem(m_fpc);
    pcEnable_i      = en;
    branch_i        = br;
    branch_target_i = tgt;
    imem_ack_i      = ack_d;
    imem_rdata_i    = rd;
    @(posedge clk_i);
    model_step(en, br, tgt, ack_d, rd);
    #1;
    check_all();
  endtask

  initial begin
    rst_i           = 1'b0;
    pcEnable_i      = 1'b0;
    branch_i        = 1'b0;
    branch_target_i = 32'd0;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = 32'd0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_all();
    check("wrap_reset_addr", addr2, WRAP_PC);
    check("wrap_reset_inst", inst2, 32'd0);
    rst_i = 1'b1;

    // IDLE exit (ack here must be ignored), then zero-wait streaming.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_first_req", {31'd0, req2}, 32'd1);
    check("wrap_first_addr", addr2, WRAP_PC);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_second_addr", addr2, 32'd0);
    check("wrap_inst", inst2, WRAP_PC);
    check("wrap_pc", pc2, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

    // Two-cycle memory latency, twice.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b1);
    end

    // Stall while an ack arrives, hold three cycles, then release the buffer.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);

    // Redirect with a request outstanding: stale response dropped.
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("redirect_addr", imem_addr_o, 32'h0000_0100);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);

    // Zero-wait redirect, redirect out of HOLD, redirect inside DROP.
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, WRAP_PC, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_br  = ($urandom_range(0, 19) == 0);
      r_tgt = $urandom();
      r_ack = ($urandom_range(0, 1) == 1);
      step(r_en, r_br, r_tgt, r_ack);
    end

    // Reset asserted mid-request: outputs clear without waiting for a clock edge.
    step(1'b1, 1'b0, 32'd0, 1'b0);
    if (!m_held) step(1'b1, 1'b0, 32'd0, 1'b0);
    #2;
    rst_i      = 1'b0;
    imem_ack_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
